// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared DFF bank arbiter: per-requester request, op and data,
// plus the grant/ack handshake and the shared register value.
interface dff_bank_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] d;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;

  modport master (output req, op, d, input gnt, ack, q, busy);
  modport slave  (input req, op, d, output gnt, ack, q, busy);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that serialises LOAD/SET/CLEAR/NOP commands from N_REQ requesters
// onto one shared WIDTH-bit register; one transaction takes IDLE -> GRANT -> ACK.
module dff_bank_arbiter #(
  parameter int unsigned     N_REQ   = 4,
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input logic             clk,
  input logic             reset,
  dff_bank_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [1:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] d_arr  [N_REQ];
  logic             found;
  logic [PTR_W-1:0] sel;

  // Unpack the flat per-requester buses into indexable arrays
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      op_arr[i] = bus.op[2*i +: 2];
      d_arr[i]  = bus.d[WIDTH*i +: WIDTH];
    end
  end

  // First active requester at or after ptr, wrapping past N_REQ-1
  always_comb begin
    int               idx_full;
    logic [PTR_W-1:0] idx;
    found    = 1'b0;
    sel      = '0;
    idx_full = 0;
    idx      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx_full = int'(ptr_q) + k;
      if (idx_full >= int'(N_REQ)) idx_full = idx_full - int'(N_REQ);
      idx = PTR_W'(idx_full);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_GRANT;
      S_GRANT: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything lands in registers below
  always_comb begin
    ptr_d  = ptr_q;
    win_d  = win_q;
    op_d   = op_q;
    dat_d  = dat_q;
    q_d    = q_q;
    gnt_d  = '0;
    ack_d  = '0;
    busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d  = sel;
          op_d   = op_arr[sel];
          dat_d  = d_arr[sel];
          gnt_d  = N_REQ'(1) << sel;
          busy_d = 1'b1;
        end
      end
      S_GRANT: begin
        case (op_q)
          OP_LOAD:  q_d = dat_q;
          OP_SET:   q_d = SET_VAL;
          OP_CLEAR: q_d = '0;
          default:  q_d = q_q;
        endcase
        ack_d  = N_REQ'(1) << win_q;
        ptr_d  = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and latched command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      win_q  <= '0;
      op_q   <= '0;
      dat_q  <= '0;
      q_q    <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      win_q  <= win_d;
      op_q   <= op_d;
      dat_q  <= dat_d;
      q_q    <= q_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = q_q;
  assign bus.busy = busy_q;

  // Handshake sanity: grant and acknowledge are exclusive and at most one-hot
  a_gnt_ack_excl: assert property (@(posedge clk) disable iff (!reset)
    !((|gnt_q) && (|ack_q)));
  a_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(gnt_q) && $onehot0(ack_q));

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomised and directed bench for dff_bank_arbiter against a transaction-level model
// (round-robin pick from a pointer, register update by op).
module tb_dff_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef logic [2*N+1+W-1:0] obs_t;

  logic clk = 1'b0;
  logic reset;

  dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .SET_VAL(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_q;
  int           m_ptr;

  function automatic logic [N-1:0] oh(int w);
    return (w < 0) ? '0 : N'(1) << w;
  endfunction

  function automatic int m_pick(logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] m_apply(logic [1:0] o, logic [W-1:0] dd, logic [W-1:0] cur);
    case (o)
      2'b00:   return dd;
      2'b01:   return 8'hFF;
      2'b10:   return 8'h00;
      default: return cur;
    endcase
  endfunction

  function automatic obs_t obs();
    return {bus.gnt, bus.ack, bus.busy, bus.q};
  endfunction

  function automatic obs_t expv(logic [N-1:0] g, logic [N-1:0] a, logic b, logic [W-1:0] qq);
    return {g, a, b, qq};
  endfunction

  task automatic set_req(input logic [N-1:0] r, input logic [2*N-1:0] o, input logic [W*N-1:0] dd);
    bus.req = r;
    bus.op  = o;
    bus.d   = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    m_q   = '0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b0;
    set_req('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    e = expv('0, '0, 1'b0, 8'h00);
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_hold: observed %h expected %h", obs(), e); end
    @(negedge clk);
    reset = 1'b1;
    m_q   = '0;
    m_ptr = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL idle_after_reset[%0d]: observed %h expected %h", c, obs(), e); end
    end
  endtask

  // Table of directed transactions: request, ops, data; each one checked through all three phases
  task automatic test_single_load_set_clear();
    logic [N-1:0]   r  [3] = '{4'b0001, 4'b0100, 4'b0010};
    logic [2*N-1:0] o  [3] = '{8'hFC, 8'hDF, 8'hEF};
    logic [W*N-1:0] dd [3] = '{32'h000000A5, 32'h00000000, 32'h00000000};
    for (int t = 0; t < 3; t++) begin
      int w; logic [W-1:0] q0, q1; obs_t e;
      set_req(r[t], o[t], dd[t]);
      w  = m_pick(r[t]);
      q0 = m_q;
      q1 = m_apply(2'(o[t] >> (2*w)), W'(dd[t] >> (W*w)), m_q);
      tick();
      e = expv(oh(w), '0, 1'b1, q0);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL directed[%0d]_grant: observed %h expected %h", t, obs(), e); end
      tick();
      m_q = q1; m_ptr = (w + 1) % N;
      set_req('0, '0, '0);
      e = expv('0, oh(w), 1'b1, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL directed[%0d]_ack: observed %h expected %h", t, obs(), e); end
      tick();
      e = expv('0, '0, 1'b0, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL directed[%0d]_idle: observed %h expected %h", t, obs(), e); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(4'hF, 8'h00, 32'h40302010);
    for (int t = 0; t < 5; t++) begin
      int w; logic [W-1:0] q0, q1; obs_t e;
      w  = m_pick(4'hF);
      q0 = m_q;
      q1 = W'(32'h40302010 >> (W*w));
      tick();
      e = expv(oh(w), '0, 1'b1, q0);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr[%0d]_grant: observed %h expected %h", t, obs(), e); end
      tick();
      m_q = q1; m_ptr = (w + 1) % N;
      e = expv('0, oh(w), 1'b1, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr[%0d]_ack: observed %h expected %h", t, obs(), e); end
      tick();
      e = expv('0, '0, 1'b0, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr[%0d]_idle: observed %h expected %h", t, obs(), e); end
    end
    set_req('0, '0, '0);
  endtask

  // Requester 3 withdraws during GRANT, then requester 0 issues NOP
  task automatic test_withdraw_nop();
    logic [N-1:0]   r  [2] = '{4'b1000, 4'b0001};
    logic [2*N-1:0] o  [2] = '{8'h3F, 8'hFF};
    logic [W*N-1:0] dd [2] = '{32'h5A000000, 32'h000000C3};
    for (int t = 0; t < 2; t++) begin
      int w; logic [W-1:0] q0, q1; obs_t e;
      set_req(r[t], o[t], dd[t]);
      w  = m_pick(r[t]);
      q0 = m_q;
      q1 = m_apply(2'(o[t] >> (2*w)), W'(dd[t] >> (W*w)), m_q);
      tick();
      set_req('0, 8'hAA, 32'hDEADBEEF);
      e = expv(oh(w), '0, 1'b1, q0);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL withdraw[%0d]_grant: observed %h expected %h", t, obs(), e); end
      tick();
      m_q = q1; m_ptr = (w + 1) % N;
      e = expv('0, oh(w), 1'b1, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL withdraw[%0d]_ack: observed %h expected %h", t, obs(), e); end
      tick();
      e = expv('0, '0, 1'b0, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL withdraw[%0d]_idle: observed %h expected %h", t, obs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    int w; logic [W-1:0] q1; obs_t e;
    set_req(4'b0010, 8'hF3, 32'h00003C00);
    w = m_pick(4'b0010);
    tick();
    e = expv(oh(w), '0, 1'b1, m_q);
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rstmid_grant: observed %h expected %h", obs(), e); end
    reset = 1'b0;
    #1;
    m_q = '0; m_ptr = 0;
    e = expv('0, '0, 1'b0, 8'h00);
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rstmid_async: observed %h expected %h", obs(), e); end
    set_req(4'hF, 8'h00, 32'h44332211);
    tick();
    @(negedge clk);
    reset = 1'b1;
    w  = m_pick(4'hF);
    q1 = W'(32'h44332211 >> (W*w));
    tick();
    e = expv(oh(w), '0, 1'b1, 8'h00);
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rstmid_restart_grant: observed %h expected %h", obs(), e); end
    tick();
    m_q = q1; m_ptr = (w + 1) % N;
    set_req('0, '0, '0);
    e = expv('0, oh(w), 1'b1, q1);
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rstmid_restart_ack: observed %h expected %h", obs(), e); end
    tick();
  endtask

  // Random requests, ops and data; inputs scrambled while busy must be ignored
  task automatic test_random();
    for (int t = 0; t < 80; t++) begin
      logic [N-1:0] r; logic [2*N-1:0] o; logic [W*N-1:0] dd;
      int w; logic [W-1:0] q0, q1; obs_t e;
      r  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      o  = (2*N)'($urandom);
      dd = (W*N)'($urandom);
      set_req(r, o, dd);
      if (r == '0) begin
        tick();
        e = expv('0, '0, 1'b0, m_q);
        n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rand[%0d]_idle_noreq: observed %h expected %h", t, obs(), e); end
        continue;
      end
      w  = m_pick(r);
      q0 = m_q;
      q1 = m_apply(2'(o >> (2*w)), W'(dd >> (W*w)), m_q);
      tick();
      set_req(N'($urandom), (2*N)'($urandom), (W*N)'($urandom));
      e = expv(oh(w), '0, 1'b1, q0);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rand[%0d]_grant: observed %h expected %h", t, obs(), e); end
      tick();
      m_q = q1; m_ptr = (w + 1) % N;
      set_req(N'($urandom), (2*N)'($urandom), (W*N)'($urandom));
      e = expv('0, oh(w), 1'b1, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rand[%0d]_ack: observed %h expected %h", t, obs(), e); end
      tick();
      e = expv('0, '0, 1'b0, q1);
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rand[%0d]_idle: observed %h expected %h", t, obs(), e); end
    end
    set_req('0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    set_req('0, '0, '0);
    m_q   = '0;
    m_ptr = 0;
    test_reset();
    test_single_load_set_clear();
    test_round_robin();
    test_withdraw_nop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit flip-flop register (load/set/clear semantics) between N_REQ requesters.
- Selects one requester per transaction by round-robin, latches its command and data, applies it to the register, then acknowledges.
- Sits between the requester blocks and the shared DFF bank. It is the only writer of q.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register width in bits
- SET_VAL, all ones ({WIDTH{1'b1}}), value loaded by the SET op

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; 0 clears all state immediately
- req  input  N_REQ  per-requester request level, bit i = requester i
- op  input  2*N_REQ  per-requester op, bits [2i+1:2i]: 00 LOAD, 01 SET, 10 CLEAR, 11 NOP
- d  input  WIDTH*N_REQ  per-requester data, bits [WIDTH*i +: WIDTH], used by LOAD only
- gnt  output  N_REQ  one-hot grant, high for exactly the GRANT cycle
- ack  output  N_REQ  one-hot acknowledge, high for exactly the ACK cycle
- q  output  WIDTH  shared register contents
- busy  output  1  high in GRANT and ACK states

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, q=0, gnt=0, ack=0, busy=0, round-robin pointer ptr=0, latched op/data=0.
  - Reset deasserts synchronously in effect; the first transition is evaluated on the first rising edge with reset=1.
- FSM states are IDLE, GRANT and ACK. Three cycles per transaction; maximum throughput is one transaction per 3 clocks.
- IDLE:
  - If req != 0 on a rising edge, pick the winner w = the first index with req[w]=1, searching from ptr upward and wrapping from N_REQ-1 to 0.
  - On that edge: latch op[w] and d[w], set gnt = 1<<w, go to GRANT.
  - If req == 0, stay in IDLE with all outputs 0 except q.
- GRANT (gnt high, busy high):
  - On the next edge, update q from the latched op: LOAD writes q=latched d; SET writes q=SET_VAL; CLEAR writes q=0; NOP leaves q unchanged.
  - On the same edge: gnt=0, ack=1<<w, ptr=(w+1) mod N_REQ, go to ACK.
- ACK (ack high, busy high): on the next edge ack=0, go to IDLE.
- Latency: req sampled at edge E0 gives gnt during E0→E1, q new value after E1, ack during E1→E2, IDLE after E2.
- Requester rules:
  - A requester must hold req, op and d stable until the edge it sees gnt; only the values at the grant edge matter.
  - After ack, the requester drops req or re-requests. A held req is treated as a new request in the next IDLE.
- Boundary conditions:
  - Request withdrawn during GRANT or ACK: the transaction still completes using the latched values.
  - req changes while busy: ignored until IDLE.
  - All requesters active: strict rotation, 0,1,2,3,0… for N_REQ=4. No requester waits more than N_REQ transactions.
  - ptr wraps from N_REQ-1 to 0.
  - Reset asserted in GRANT: q stays 0 and the pending update is discarded. Reset asserted in ACK: q is cleared, ack drops immediately.
  - gnt and ack are never high together, and each is never more than one bit hot.

Test Plan:
- Reset then idle: reset=0 for 2 clocks, then 1, req=0 for 5 clocks → q=0, gnt=0, ack=0, busy=0 throughout.
- Single LOAD: req=0001, op0=00, d0=8'hA5 → gnt=0001 one cycle, then q=8'hA5 with ack=0001 one cycle, then busy=0.
- SET then CLEAR: requester 2 issues SET → q=8'hFF, ack=0100. Requester 1 then issues CLEAR → q=8'h00, ack=0010.
- Round-robin fairness: req=1111 held, op=LOAD with d0..d3=8'h10,8'h20,8'h30,8'h40 → gnt sequence 0001,0010,0100,1000,0001, q values 10,20,30,40,10, one grant every 3 cycles.
- Withdrawal and NOP: requester 3 LOAD 8'h5A, req3 dropped during GRANT → q=8'h5A and ack=1000 still issued. Requester 0 NOP → q unchanged, ack=0001.
- Reset mid-operation: requester 1 LOAD 8'h3C, pull reset=0 during GRANT → gnt, ack and busy drop immediately, q=0. After release, the next winner search starts at index 0.
